uart_tx_core_param: RTL and testbench

Parametrised next-generation UART transmitter.
- Buffers bytes in an internal FIFO of configurable depth.
- Serialises each frame on baud-tick boundaries: runtime-selectable data length (5–8 bits), bit order, parity mode and stop-bit count.
- Sits between the host write port and the pad, driven by the shared baud-rate generator's one-cycle tick.
- Adds a fill-level output and a sticky overflow flag.

---
 rtl/uart_tx_core_param.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_core_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core_param.sv
// UART transmitter with a write FIFO, runtime frame format (5-8 data bits, bit order,
// parity, 1/2 stop bits), fill level and sticky overflow. Optional break: UART_TX_BREAK_EN.
module uart_tx_core_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             n_we_i,
  output logic             p_full_o,
  output logic             p_empty_o,
  output logic [FIFO_AW:0] Level_o,
  output logic             p_Overflow_o,
  input  logic             p_OvfClr_i,
  input  logic             p_BaudSig_i,
  input  logic [1:0]       DataLen_i,
  input  logic             p_BigEnd_i,
  input  logic             p_ParityEnable_i,
  input  logic             ParityMethod_i,
  input  logic             p_TwoStop_i,
`ifdef UART_TX_BREAK_EN
  input  logic             p_Break_i,
`endif
  output logic             p_Busy_o,
  output logic             Tx_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
  } state_t;

  localparam logic [FIFO_AW:0] LP_DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_ovf;

  state_t     r_state;
  logic       r_tx, r_busy;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_par;
  logic [1:0] r_len;
  logic       r_par_en, r_par_odd, r_two_stop;

  logic       w_full, w_empty, w_wr, w_pop, w_break;
  logic [7:0] w_head, w_rev, w_load;
  logic [2:0] w_last_idx;

`ifdef UART_TX_BREAK_EN
  assign w_break = p_Break_i;
`else
  assign w_break = 1'b0;
`endif

  assign w_full     = (r_level == LP_DEPTH);
  assign w_empty    = (r_level == '0);
  assign w_wr       = !n_we_i && !w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_last_idx = 3'(r_len) + 3'd4;

  // Pop only at a frame start: from IDLE, or straight out of the last stop bit.
  assign w_pop = p_BaudSig_i && !w_empty &&
                 (((r_state == ST_IDLE) && !w_break) ||
                  ((r_state == ST_STOP1) && !r_two_stop) ||
                  (r_state == ST_STOP2));

  // The shift register always sends bit 0 first, so MSB-first frames are reversed on load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_rev = '0;
    case (DataLen_i)
      2'b00: w_rev = {3'b000, w_head[0], w_head[1], w_head[2], w_head[3], w_head[4]};
      2'b01: w_rev = {2'b00, w_head[0], w_head[1], w_head[2], w_head[3], w_head[4], w_head[5]};
      2'b10: w_rev = {1'b0, w_head[0], w_head[1], w_head[2], w_head[3], w_head[4], w_head[5],
                      w_head[6]};
      default: w_rev = {w_head[0], w_head[1], w_head[2], w_head[3], w_head[4], w_head[5],
                        w_head[6], w_head[7]};
    endcase
    w_load = p_BigEnd_i ? w_rev : w_head;
  end

  // NOTE: FIFO storage has no reset; the pointers and level alone define its contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (!n_we_i && w_full) r_ovf <= 1'b1;
      else if (p_OvfClr_i)   r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_len      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (w_pop) begin
      r_state    <= ST_START;
      r_tx       <= 1'b0;
      r_busy     <= 1'b1;
      r_shift    <= w_load;
      r_par      <= 1'b0;
      r_len      <= DataLen_i;
      r_par_en   <= p_ParityEnable_i;
      r_par_odd  <= ParityMethod_i;
      r_two_stop <= p_TwoStop_i;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= !w_break;
          r_busy <= w_break;
        end
        ST_START: if (p_BaudSig_i) begin
          r_tx      <= r_shift[0];
          r_par     <= r_par ^ r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= '0;
          r_state   <= ST_DATA;
        end
        ST_DATA: if (p_BaudSig_i) begin
          if (r_bit_cnt == w_last_idx) begin
            if (r_par_en) begin
              r_tx    <= r_par ^ r_par_odd;
              r_state <= ST_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP1;
            end
          end else begin
            r_tx      <= r_shift[0];
            r_par     <= r_par ^ r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_PARITY: if (p_BaudSig_i) begin
          r_tx    <= 1'b1;
          r_state <= ST_STOP1;
        end
        ST_STOP1: if (p_BaudSig_i) begin
          if (r_two_stop) begin
            r_state <= ST_STOP2;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_STOP2: if (p_BaudSig_i) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign p_full_o     = w_full;
  assign p_empty_o    = w_empty;
  assign Level_o      = r_level;
  assign p_Overflow_o = r_ovf;
  assign p_Busy_o     = r_busy;
  assign Tx_o         = r_tx;

endmodule

// File: tb/tb_uart_tx_core_param.sv
// Bench for uart_tx_core_param: a queue-based frame model checked every cycle, plus
// hand-computed line sequences for the documented frame formats.
module tb_uart_tx_core_param;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    data_i = '0;
  logic          n_we_i = 1'b1;
  logic          p_full_o, p_empty_o, p_Overflow_o, p_Busy_o, Tx_o;
  logic [AW:0]   Level_o;
  logic          p_OvfClr_i = 1'b0;
  logic          p_BaudSig_i = 1'b0;
  logic [1:0]    DataLen_i = 2'b11;
  logic          p_BigEnd_i = 1'b0;
  logic          p_ParityEnable_i = 1'b0;
  logic          ParityMethod_i = 1'b0;
  logic          p_TwoStop_i = 1'b0;

  uart_tx_core_param #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .n_we_i(n_we_i),
    .p_full_o(p_full_o), .p_empty_o(p_empty_o), .Level_o(Level_o),
    .p_Overflow_o(p_Overflow_o), .p_OvfClr_i(p_OvfClr_i), .p_BaudSig_i(p_BaudSig_i),
    .DataLen_i(DataLen_i), .p_BigEnd_i(p_BigEnd_i), .p_ParityEnable_i(p_ParityEnable_i),
    .ParityMethod_i(ParityMethod_i), .p_TwoStop_i(p_TwoStop_i),
    .p_Busy_o(p_Busy_o), .Tx_o(Tx_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en  = 1'b0;
  bit tick_en = 1'b0;
  int tick_cnt = 0;
  bit cap[$];

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Baud tick: one clk wide, every 16 clocks while enabled.
  always @(negedge clk) begin
    tick_cnt    = (tick_cnt + 1) % 16;
    p_BaudSig_i = tick_en && (tick_cnt == 0);
  end

  // Model: the line is a queue of bits; a frame is expanded from the format rules when it starts.
  logic [7:0] m_fifo[$];
  bit         m_q[$];
  bit         m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0;
  bit         m_full, m_empty, m_bit;
  logic [7:0] m_b;
  int         m_n, m_ones;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete();
      m_q.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_ovf = 1'b0;
    end else begin
      m_full  = (m_fifo.size() == DEPTH);
      m_empty = (m_fifo.size() == 0);
      if (p_BaudSig_i) begin
        if (m_q.size() != 0) begin
          m_tx = m_q.pop_front();
        end else if (!m_empty) begin
          m_b    = m_fifo.pop_front();
          m_n    = int'(DataLen_i) + 5;
          m_ones = 0;
          m_q.push_back(1'b0);
          for (int i = 0; i < m_n; i++) begin
            m_bit  = m_b[p_BigEnd_i ? (m_n - 1 - i) : i];
            m_ones = m_ones + int'(m_bit);
            m_q.push_back(m_bit);
          end
          if (p_ParityEnable_i) m_q.push_back(m_ones[0] ^ ParityMethod_i);
          m_q.push_back(1'b1);
          if (p_TwoStop_i) m_q.push_back(1'b1);
          m_tx   = m_q.pop_front();
          m_busy = 1'b1;
        end else begin
          m_tx = 1'b1; m_busy = 1'b0;
        end
      end
      if (!n_we_i && m_full)  m_ovf = 1'b1;
      else if (p_OvfClr_i)    m_ovf = 1'b0;
      if (!n_we_i && !m_full) m_fifo.push_back(data_i);
    end
  end

  bit cmp_tick;
  always @(posedge clk) begin
    cmp_tick = p_BaudSig_i;
    #1;
    if (chk_en && rst) begin
      check("tx",    16'(Tx_o),         16'(m_tx));
      check("busy",  16'(p_Busy_o),     16'(m_busy));
      check("level", 16'(Level_o),      16'(m_fifo.size()));
      check("full",  16'(p_full_o),     16'(m_fifo.size() == DEPTH));
      check("empty", 16'(p_empty_o),    16'(m_fifo.size() == 0));
      check("ovf",   16'(p_Overflow_o), 16'(m_ovf));
      if (cmp_tick) cap.push_back(Tx_o);
    end
  end

  function automatic logic cap_at(int i);
    return (i < cap.size()) ? logic'(cap[i]) : 1'bx;
  endfunction

  task automatic write_byte(logic [7:0] b);
    @(negedge clk);
    data_i = b;
    n_we_i = 1'b0;
    @(negedge clk);
    n_we_i = 1'b1;
  endtask

  task automatic set_cfg(logic [1:0] len, logic big, logic pen, logic odd, logic two);
    DataLen_i = len; p_BigEnd_i = big; p_ParityEnable_i = pen;
    ParityMethod_i = odd; p_TwoStop_i = two;
  endtask

  // Sends one byte from an empty, idle transmitter and compares the bit seen after each tick.
  task automatic run_frame(string name, logic [7:0] b, int nb, logic [15:0] exp, bit scramble);
    logic [15:0] got;
    tick_en = 1'b0;
    write_byte(b);
    cap.delete();
    tick_en = 1'b1;
    if (scramble) begin
      repeat (3 * 16) @(negedge clk);
      set_cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat ((nb - 1) * 16) @(negedge clk);
    end else begin
      repeat ((nb + 2) * 16) @(negedge clk);
    end
    tick_en = 1'b0;
    got = '0;
    for (int i = 0; i < nb; i++) got = {got[14:0], cap_at(i)};
    check(name, got, exp);
    check({name, "_idle_tx"}, 16'(cap_at(nb)), 16'd1);
    check({name, "_busy_end"}, 16'(p_Busy_o), 16'd0);
  endtask

  logic [15:0] g;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx",    16'(Tx_o),         16'd1);
    check("rst_full",  16'(p_full_o),     16'd0);
    check("rst_empty", 16'(p_empty_o),    16'd1);
    check("rst_level", 16'(Level_o),      16'd0);
    check("rst_ovf",   16'(p_Overflow_o), 16'd0);
    check("rst_busy",  16'(p_Busy_o),     16'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("8N1_A5", 8'hA5, 10, 16'(10'b0101001011), 1'b0);
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    run_frame("7E2_53", 8'h53, 11, 16'(11'b01010011011), 1'b0);
    set_cfg(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame("5O1_FF", 8'hFF, 8, 16'(8'b01111101), 1'b1);

    // Overfill a 4-deep FIFO with ticks stopped, then drain back-to-back.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_en = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h31 + i));
    check("fill_level", 16'(Level_o),      16'd4);
    check("fill_full",  16'(p_full_o),     16'd1);
    check("fill_ovf",   16'(p_Overflow_o), 16'd1);
    @(negedge clk); p_OvfClr_i = 1'b1;
    @(negedge clk); p_OvfClr_i = 1'b0;
    check("ovf_clr", 16'(p_Overflow_o), 16'd0);
    cap.delete();
    tick_en = 1'b1;
    repeat (42 * 16) @(negedge clk);
    tick_en = 1'b0;
    check("drain_empty", 16'(p_empty_o), 16'd1);
    g = 16'({cap_at(0), cap_at(10), cap_at(20), cap_at(30), cap_at(40)});
    check("b2b_starts", g, 16'(5'b00001));
    g = '0;
    for (int i = 7; i >= 0; i--) g = {g[14:0], cap_at(1 + i)};
    check("b2b_first", g, 16'h31);
    g = '0;
    for (int i = 7; i >= 0; i--) g = {g[14:0], cap_at(31 + i)};
    check("b2b_fourth", g, 16'h34);

    // Reset in the middle of a data phase with a second byte still queued.
    write_byte(8'h3C);
    write_byte(8'h55);
    tick_en = 1'b1;
    repeat (4 * 16) @(negedge clk);
    check("mid_busy", 16'(p_Busy_o), 16'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_tx",    16'(Tx_o),    16'd1);
    check("mid_rst_level", 16'(Level_o), 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6 * 16) @(negedge clk);
    tick_en = 1'b0;
    check("post_rst_tx",    16'(Tx_o),      16'd1);
    check("post_rst_busy",  16'(p_Busy_o),  16'd0);
    check("post_rst_empty", 16'(p_empty_o), 16'd1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
